procesador_fifo_parametros_tx: RTL
==================================

PROCESADOR_FIFO_PARAMETROS_TX -- requirements
Module: procesador_fifo_parametros_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stream and register data width.
REQ-002 SHALL have parameter DEPTH, default 256, storage words (power of two, >=4).
REQ-003 SHALL have port wrclock  in  1  single clock for all logic.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port avalonmm_write_slave_address  in  2  register select: 0=DATA, 1=STATUS/CTRL, 2=OVFCNT.
REQ-006 SHALL have port avalonmm_write_slave_write  in  1  write strobe.
REQ-007 SHALL have port avalonmm_write_slave_writedata  in  32  write data.
REQ-008 SHALL have port avalonmm_write_slave_read  in  1  read strobe.
REQ-009 SHALL have port avalonmm_write_slave_readdata  out  32  read data, zero wait states, combinational from registered state.
REQ-010 SHALL have port avalonst_source_data  out  DATA_W  stream word.
REQ-011 SHALL have port avalonst_source_valid  out  1  stream word present.
REQ-012 SHALL have port avalonst_source_ready  in  1  downstream accepts.
REQ-013 SHALL have ports fifo_empty and fifo_full  out  1 each  level==0 / level==DEPTH.

Function
REQ-014 SHALL push writedata when write=1, address=0 and fifo_full=0 at the edge.
REQ-015 SHALL drop a DATA write when fifo_full=1 before the edge, even if a pop occurs the same cycle, and set sticky flag ovf.
REQ-016 SHALL count level over memory plus output register; level changes +1 on push only, -1 on pop only, unchanged on both.
REQ-017 SHALL pop on avalonst_source_valid && avalonst_source_ready.
REQ-018 SHALL hold avalonst_source_data stable while valid=1 and ready=0.
REQ-019 SHALL present a word pushed into an empty FIFO with valid=1 one cycle after the write edge (bypass into output register).
REQ-020 SHALL, when not empty, sustain one pop per cycle with ready held high; order strictly FIFO.
REQ-021 SHALL wrap read/write pointers modulo DEPTH without a gap or duplicate.
REQ-022 SHALL return STATUS at address 1: bit31 ovf, bit30 full, bit29 empty, bits[15:0] level.
REQ-023 SHALL on write to address 1: bit0=1 flush (level=0, valid=0 next cycle), bit1=1 clear ovf.
REQ-024 SHALL give flush priority over a same-cycle DATA write (write dropped, ovf unchanged) and over a same-cycle pop.
REQ-025 SHALL return 0 on reads of address 3 and ignore writes to addresses 2 and 3.
REQ-026 SHALL have no side effects from MM reads.

Reset
REQ-027 SHALL on reset: pointers 0, level 0, valid 0, source_data 0, ovf 0, fifo_empty 1, fifo_full 0, OVFCNT 0.
REQ-028 SHALL, on reset asserted mid-burst, discard all contents; writes during reset are ignored.

Configuration
REQ-029 SHALL with PROCESADOR_FIFO_TX_OVFCNT_EN defined implement a 32-bit saturating count of dropped DATA writes, read at address 2, cleared by STATUS bit1 write.
REQ-030 SHALL without PROCESADOR_FIFO_TX_OVFCNT_EN return 0 at address 2 and omit the counter.

Structure
REQ-031 SHALL take register address constants, STATUS/CTRL bit positions and the reset status value from shared package procesador_fifo_pkg.
REQ-032 SHALL isolate storage and pointers in sub-module procesador_fifo_tx_mem (simple dual-port, registered read); output stage and MM decode stay in top.

Verification
REQ-033 SHALL cover: reset, write 0xA5A5_0001 to addr 0, ready=1 -> valid high 1 cycle later with data 0xA5A5_0001, then valid=0, STATUS=0x2000_0000.
REQ-034 SHALL cover: 256 writes 0..255 with ready=0 -> full=1, STATUS level=256; 257th write 0xDEAD dropped, ovf=1, OVFCNT=1 (macro on).
REQ-035 SHALL cover: FIFO full, ready pulsed with a simultaneous write -> one word popped, write dropped, level=255.
REQ-036 SHALL cover: 600 writes interleaved with random ready -> output sequence 0..599 exact, no loss across pointer wrap.
REQ-037 SHALL cover: level 10, write 0x1 to addr 1 together with ready=1 -> next cycle level=0, valid=0, empty=1.
REQ-038 SHALL cover: reset asserted at level 50 with valid=1 -> next cycle valid=0, level=0, ovf=0; macro off -> addr 2 reads 0.

Source files
------------

// File: rtl/procesador_fifo_pkg.sv
// -----------------------------------------------------------------------------
// procesador_fifo_pkg
// Shared constants for the Avalon-MM to Avalon-ST transmit FIFO:
//   - register address map (DATA / STATUS-CTRL / OVFCNT)
//   - STATUS read bit positions and CTRL write bit positions
//   - STATUS value seen straight out of reset (empty, nothing else set)
//   - pack_status(): assembles the 32-bit STATUS word
// -----------------------------------------------------------------------------
package procesador_fifo_pkg;

    // Register map (2-bit word address)
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_OVFCNT = 2'd2;

    // STATUS read layout
    localparam int STAT_OVF_BIT   = 31;
    localparam int STAT_FULL_BIT  = 30;
    localparam int STAT_EMPTY_BIT = 29;
    localparam int STAT_LEVEL_W   = 16;

    // CTRL write layout (same address as STATUS)
    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

    // Empty FIFO, no overflow, level 0
    localparam logic [31:0] STATUS_RST = 32'h2000_0000;

    function automatic logic [31:0] pack_status(
        input logic                    ovf,
        input logic                    full,
        input logic                    empty,
        input logic [STAT_LEVEL_W-1:0] level
    );
        logic [31:0] s;
        s                          = '0;
        s[STAT_OVF_BIT]            = ovf;
        s[STAT_FULL_BIT]           = full;
        s[STAT_EMPTY_BIT]          = empty;
        s[STAT_LEVEL_W-1:0]        = level;
        return s;
    endfunction

endpackage

// File: rtl/procesador_fifo_tx_mem.sv
// -----------------------------------------------------------------------------
// procesador_fifo_tx_mem
// Storage and pointers for the transmit FIFO. Simple dual-port array with a
// registered read port. The read address is the *next* read pointer, so
// rd_data_o always holds the word at the current head of the array, which lets
// the output stage take one word per cycle with no bubble.
//
// Ports
//   clk_i      clock
//   rst_i      synchronous active-high reset (pointers to 0, writes blocked)
//   clr_i      flush: pointers to 0 next cycle, write blocked
//   wr_en_i    store wr_data_i at the write pointer and advance it
//   wr_data_i  word to store
//   rd_adv_i   head word consumed: advance the read pointer
//   rd_data_o  word at the head of the array (valid when array not empty)
// -----------------------------------------------------------------------------
module procesador_fifo_tx_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_adv_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_fire;

    assign wr_fire = wr_en_i && !rst_i && !clr_i;

    // Pointers are AW bits wide, so incrementing wraps modulo DEPTH naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en_i)  wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_adv_i) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Write-first on an address collision: a word written into an otherwise
    // empty array must show up on rd_data_o right after the write edge.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
        if (wr_fire && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_q <= wr_data_i;
        end else begin
            rd_data_q <= mem_q[rd_ptr_d];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/procesador_fifo_parametros_tx.sv
// -----------------------------------------------------------------------------
// procesador_fifo_parametros_tx
// Transmit FIFO: an Avalon-MM write slave fills it, an Avalon-ST source drains
// it. Level counts the words in the array plus the one in the output register.
//
// Ports
//   wrclock / reset                   single clock, synchronous active-high reset
//   avalonmm_write_slave_address      0=DATA (push), 1=STATUS/CTRL, 2=OVFCNT
//   avalonmm_write_slave_write        write strobe
//   avalonmm_write_slave_writedata    write data
//   avalonmm_write_slave_read         read strobe (no side effects)
//   avalonmm_write_slave_readdata     read data, zero wait states
//   avalonst_source_data/valid/ready  stream output; pop on valid && ready
//   fifo_empty / fifo_full            level == 0 / level == DEPTH
//
// STATUS read: [31] ovf (sticky), [30] full, [29] empty, [15:0] level.
// CTRL write:  [0] flush, [1] clear ovf (and the drop counter).
//
// Optional feature: define PROCESADOR_FIFO_TX_OVFCNT_EN to get a 32-bit
// saturating count of dropped DATA writes at address 2; otherwise address 2
// reads 0.
//
// Stream handshake: a word transfers on every rising edge where
// avalonst_source_valid and avalonst_source_ready are both 1; while valid is
// 1 and ready is 0 the data is held unchanged.
// -----------------------------------------------------------------------------
module procesador_fifo_parametros_tx
    import procesador_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              wrclock,
    input  logic              reset,
    input  logic [1:0]        avalonmm_write_slave_address,
    input  logic              avalonmm_write_slave_write,
    input  logic [31:0]       avalonmm_write_slave_writedata,
    input  logic              avalonmm_write_slave_read,
    output logic [31:0]       avalonmm_write_slave_readdata,
    output logic [DATA_W-1:0] avalonst_source_data,
    output logic              avalonst_source_valid,
    input  logic              avalonst_source_ready,
    output logic              fifo_empty,
    output logic              fifo_full
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [LVL_W-1:0]  level_q, level_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       status_q, status_d;

    logic              data_wr, ctrl_wr, flush, clr_ovf;
    logic              full, empty;
    logic              push, drop, pop;
    logic              mem_has, load, mem_rd_adv, bypass, mem_wr_en;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] wr_word;

    assign wr_word = avalonmm_write_slave_writedata[DATA_W-1:0];

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

    always_comb begin
        data_wr = avalonmm_write_slave_write && (avalonmm_write_slave_address == ADDR_DATA);
        ctrl_wr = avalonmm_write_slave_write && (avalonmm_write_slave_address == ADDR_STATUS);
        flush   = ctrl_wr && avalonmm_write_slave_writedata[CTRL_FLUSH_BIT];
        clr_ovf = ctrl_wr && avalonmm_write_slave_writedata[CTRL_CLR_OVF_BIT];

        // Fullness is judged before the edge: a pop in the same cycle does not
        // make room for the write. Flush beats both write and pop.
        push = data_wr && !full && !flush && !reset;
        drop = data_wr &&  full && !flush && !reset;
        pop  = out_valid_q && avalonst_source_ready && !flush;

        // Words held in the array (level minus the output register)
        mem_has = ((level_q - LVL_W'(out_valid_q)) != '0);

        // Output register takes a new word whenever it is free or being popped;
        // the array head has priority, otherwise an incoming write bypasses.
        load       = !out_valid_q || pop;
        mem_rd_adv = load && mem_has && !flush;
        bypass     = load && !mem_has && push;
        mem_wr_en  = push && !bypass;
    end

    always_comb begin
        level_d     = level_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;

        if (flush) begin
            level_d     = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else begin
            if (push && !pop)      level_d = level_q + 1'b1;
            else if (pop && !push) level_d = level_q - 1'b1;

            if (load) begin
                if (mem_has) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem_rd_data;
                end else if (push) begin
                    out_valid_d = 1'b1;
                    out_data_d  = wr_word;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end

        if (clr_ovf) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;

        status_d = pack_status(ovf_d, (level_d == LVL_W'(DEPTH)), (level_d == '0),
                               STAT_LEVEL_W'(level_d));
    end

    always_ff @(posedge wrclock) begin
        if (reset) begin
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
            status_q    <= STATUS_RST;
        end else begin
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
            status_q    <= status_d;
        end
    end

`ifdef PROCESADOR_FIFO_TX_OVFCNT_EN
    logic [31:0] ovfcnt_q;

    always_ff @(posedge wrclock) begin
        if (reset) begin
            ovfcnt_q <= '0;
        end else if (clr_ovf) begin
            ovfcnt_q <= '0;
        end else if (drop && (ovfcnt_q != 32'hFFFF_FFFF)) begin
            ovfcnt_q <= ovfcnt_q + 32'd1;
        end
    end
`endif

    procesador_fifo_tx_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i     (wrclock),
        .rst_i     (reset),
        .clr_i     (flush),
        .wr_en_i   (mem_wr_en),
        .wr_data_i (wr_word),
        .rd_adv_i  (mem_rd_adv),
        .rd_data_o (mem_rd_data)
    );

    // Read mux: purely combinational from registers, nothing changes on read.
    always_comb begin
        avalonmm_write_slave_readdata = '0;
        if (avalonmm_write_slave_read) begin
            case (avalonmm_write_slave_address)
                ADDR_STATUS: avalonmm_write_slave_readdata = status_q;
                ADDR_OVFCNT: begin
`ifdef PROCESADOR_FIFO_TX_OVFCNT_EN
                    avalonmm_write_slave_readdata = ovfcnt_q;
`else
                    avalonmm_write_slave_readdata = '0;
`endif
                end
                default:     avalonmm_write_slave_readdata = '0;
            endcase
        end
    end

    assign avalonst_source_data  = out_data_q;
    assign avalonst_source_valid = out_valid_q;
    assign fifo_empty            = empty;
    assign fifo_full             = full;

endmodule
